// File: rtl/serial_16b_pkg.sv
// Shared definitions for the 16-bit DAC serial link.
// The transmitter and the receiver both import this package.
package serial_16b_pkg;

  localparam int WORD_W = 16;
  localparam int CNT_W  = 5;

  // Bit-counter landmarks: a good frame holds exactly 16 bits.
  // Any longer frame parks the counter at 17.
  localparam logic [CNT_W-1:0] CNT_FULL = 5'd16;
  localparam logic [CNT_W-1:0] CNT_SAT  = 5'd17;

  typedef enum logic [1:0] {
    RESYNC = 2'd0,
    IDLE   = 2'd1,
    SHIFT  = 2'd2
  } rx_state_e;

  // Transmitter side of the link: 8 clk SCLK high, 8 clk SCLK low per bit.
  localparam int TX_HALF_PERIOD = 8;

  typedef enum logic [1:0] {
    TX_IDLE   = 2'd0,
    TX_SCLK_H = 2'd1,
    TX_SCLK_L = 2'd2,
    TX_DONE   = 2'd3
  } tx_state_e;

  function automatic logic [CNT_W-1:0] cnt_inc_sat(input logic [CNT_W-1:0] cnt);
    return (cnt >= CNT_SAT) ? CNT_SAT : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/serial_16b_rx_pin_sync.sv
// Pin synchronizer: STAGES flops, then a delay flop for edge detection.
// The level and the registered edge strobes are mutually time-aligned.
module pin_sync #(
  parameter int   STAGES  = 2,    // legal range 2..4
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] chain_q;
  logic              dly_q;
  logic              rise_q;
  logic              fall_q;
  logic              sync_s;

  assign sync_s = chain_q[STAGES-1];

  // NOTE: every flop here is written with <= so all stages advance on the
  // same edge; a blocking assignment would collapse the chain into one flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain_q <= {STAGES{RST_VAL}};
      dly_q   <= RST_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], pin_i};
      dly_q   <= sync_s;
      rise_q  <= sync_s & ~dly_q;
      fall_q  <= ~sync_s & dly_q;
    end
  end

  assign level_o = dly_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/serial_16b_rx.sv
// Receiver for the three-wire SYNC/SCLK/DIN link: oversamples the pins,
// shifts 16 bits MSB first and strobes valid or frame_err at frame end.
module serial_16b_rx
  import serial_16b_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter bit SAMPLE_ON_FALL = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SYNC,
  input  logic              SCLK,
  input  logic              DIN,
  output logic [WORD_W-1:0] data,
  output logic              valid,
  output logic              frame_err,
  output logic              busy
);

  // Synchronizer contents at reset are stale; RESYNC ignores the SYNC level
  // until the whole chain has been refilled from the pin.
  localparam logic [2:0] FLUSH_CYC = 3'(SYNC_STAGES + 1);

  logic sync_lvl, sync_rise, sync_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic din_lvl, din_rise, din_fall;
  logic sclk_edge;
  logic unused_pins;

  pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_pin (
    .clk     (clk),
    .rst_n   (rst_n),
    .pin_i   (SYNC),
    .level_o (sync_lvl),
    .rise_o  (sync_rise),
    .fall_o  (sync_fall)
  );

  pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_pin (
    .clk     (clk),
    .rst_n   (rst_n),
    .pin_i   (SCLK),
    .level_o (sclk_lvl),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_din_pin (
    .clk     (clk),
    .rst_n   (rst_n),
    .pin_i   (DIN),
    .level_o (din_lvl),
    .rise_o  (din_rise),
    .fall_o  (din_fall)
  );

  assign sclk_edge   = SAMPLE_ON_FALL ? sclk_fall : sclk_rise;
  assign unused_pins = ^{sclk_lvl, din_rise, din_fall};

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [2:0]        flush_q, flush_d;
  logic              busy_q, busy_d;
  logic              end_ok_q, end_ok_d;
  logic              end_err_q, end_err_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  // NOTE: every signal gets its default before the case, so no path through
  // this block can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    busy_d    = busy_q;
    end_ok_d  = 1'b0;
    end_err_d = 1'b0;
    flush_d   = (flush_q < FLUSH_CYC) ? flush_q + 3'd1 : flush_q;
    // Frame verdict is taken one cycle after SYNC rises, then published.
    valid_d   = end_ok_q;
    err_d     = end_err_q;
    data_d    = end_ok_q ? shift_q : data_q;

    unique case (state_q)
      RESYNC: begin
        busy_d = 1'b0;
        if (flush_q == FLUSH_CYC && sync_lvl) state_d = IDLE;
      end
      IDLE: begin
        if (sync_fall) begin
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // SYNC deassertion wins over a coincident SCLK edge.
        if (sync_rise) begin
          busy_d  = 1'b0;
          state_d = IDLE;
          if (cnt_q == CNT_FULL) end_ok_d  = 1'b1;
          else                   end_err_d = 1'b1;
        end else if (sclk_edge && !sync_lvl) begin
          shift_d = {shift_q[WORD_W-2:0], din_lvl};
          cnt_d   = cnt_inc_sat(cnt_q);
        end
      end
      default: begin
        state_d = RESYNC;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RESYNC;
      cnt_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      flush_q   <= '0;
      busy_q    <= 1'b0;
      end_ok_q  <= 1'b0;
      end_err_q <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      flush_q   <= flush_d;
      busy_q    <= busy_d;
      end_ok_q  <= end_ok_d;
      end_err_q <= end_err_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_serial_16b_rx.sv
// Directed bench for serial_16b_rx: a fall-sampling 2-stage instance plus a
// rise-sampling 3-stage instance, driven from one emulated transmitter.
module tb_serial_16b_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sync_pin, sclk_pin, din_pin;
  logic [15:0] data0, data1;
  logic        valid0, err0, busy0;
  logic        valid1, err1, busy1;

  int n_vec = 0;
  int n_err = 0;
  int valid_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  serial_16b_rx #(.SYNC_STAGES(2), .SAMPLE_ON_FALL(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .SYNC(sync_pin), .SCLK(sclk_pin), .DIN(din_pin),
    .data(data0), .valid(valid0), .frame_err(err0), .busy(busy0)
  );

  serial_16b_rx #(.SYNC_STAGES(3), .SAMPLE_ON_FALL(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .SYNC(sync_pin), .SCLK(sclk_pin), .DIN(din_pin),
    .data(data1), .valid(valid1), .frame_err(err1), .busy(busy1)
  );

  // Counts high cycles, so a strobe stretched to two cycles counts twice.
  always @(negedge clk) begin
    if (valid0) valid_cnt++;
    if (err0)   err_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bits first..first+n-1 of w, MSB first; positions past bit 15 send 0.
  // DIN is stable long before both the rising and the falling SCLK edge.
  task automatic send_bits(input logic [15:0] w, input int first, input int n);
    sync_pin = 1'b0;
    cyc(4);
    for (int i = first; i < first + n; i++) begin
      din_pin  = (i < 16) ? w[15-i] : 1'b0;
      sclk_pin = 1'b0;
      cyc(4);
      sclk_pin = 1'b1;
      cyc(8);
      sclk_pin = 1'b0;
      cyc(4);
    end
  endtask

  task automatic frame(input logic [15:0] w, input int n);
    send_bits(w, 0, n);
    sync_pin = 1'b1;
    din_pin  = 1'b0;
    cyc(12);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; sync_pin = 1'b1; sclk_pin = 1'b0; din_pin = 1'b0;
    cyc(4);
    n_vec++; if (data0 !== 16'h0000) begin n_err++; $display("FAIL reset_data0: got %h want 0000", data0); end
    n_vec++; if (valid0 !== 1'b0) begin n_err++; $display("FAIL reset_valid0: got %b want 0", valid0); end
    n_vec++; if (err0 !== 1'b0) begin n_err++; $display("FAIL reset_err0: got %b want 0", err0); end
    n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL reset_busy0: got %b want 0", busy0); end
    n_vec++; if (data1 !== 16'h0000) begin n_err++; $display("FAIL reset_data1: got %h want 0000", data1); end
    n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL reset_busy1: got %b want 0", busy1); end
    rst_n = 1'b1;
    cyc(10);
  endtask

  task automatic test_empty_frame;
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    sync_pin = 1'b0;
    cyc(6);
    n_vec++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL empty_busy: got %b want 1", busy0); end
    sync_pin = 1'b1;
    cyc(12);
    n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL empty_busy_end: got %b want 0", busy0); end
    n_vec++; if (err_cnt - e0 !== 1) begin n_err++; $display("FAIL empty_err: got %0d pulses want 1", err_cnt - e0); end
    n_vec++; if (valid_cnt - v0 !== 0) begin n_err++; $display("FAIL empty_valid: got %0d pulses want 0", valid_cnt - v0); end
  endtask

  task automatic test_loopback;
    logic [15:0] words [4] = '{16'hA5C3, 16'h0001, 16'hFFFF, 16'h8000};
    int v0, e0;
    for (int k = 0; k < 4; k++) begin
      v0 = valid_cnt; e0 = err_cnt;
      frame(words[k], 16);
      n_vec++; if (valid_cnt - v0 !== 1) begin n_err++; $display("FAIL loop_valid[%0d]: got %0d pulses want 1", k, valid_cnt - v0); end
      n_vec++; if (err_cnt - e0 !== 0) begin n_err++; $display("FAIL loop_err[%0d]: got %0d pulses want 0", k, err_cnt - e0); end
      n_vec++; if (data0 !== words[k]) begin n_err++; $display("FAIL loop_data[%0d]: got %h want %h", k, data0, words[k]); end
    end
  endtask

  task automatic test_short_frame;
    int v0, e0;
    frame(16'hA5C3, 16);
    v0 = valid_cnt; e0 = err_cnt;
    frame(16'hFFFF, 15);
    n_vec++; if (err_cnt - e0 !== 1) begin n_err++; $display("FAIL short_err: got %0d pulses want 1", err_cnt - e0); end
    n_vec++; if (valid_cnt - v0 !== 0) begin n_err++; $display("FAIL short_valid: got %0d pulses want 0", valid_cnt - v0); end
    n_vec++; if (data0 !== 16'hA5C3) begin n_err++; $display("FAIL short_data: got %h want a5c3", data0); end
  endtask

  task automatic test_overrun;
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_bits(16'h0F0F, 0, 18);
    n_vec++; if (dut0.cnt_q !== 5'd17) begin n_err++; $display("FAIL overrun_cnt: got %0d want 17", dut0.cnt_q); end
    sync_pin = 1'b1;
    cyc(12);
    n_vec++; if (err_cnt - e0 !== 1) begin n_err++; $display("FAIL overrun_err: got %0d pulses want 1", err_cnt - e0); end
    n_vec++; if (valid_cnt - v0 !== 0) begin n_err++; $display("FAIL overrun_valid: got %0d pulses want 0", valid_cnt - v0); end
    n_vec++; if (data0 !== 16'hA5C3) begin n_err++; $display("FAIL overrun_data: got %h want a5c3", data0); end
  endtask

  task automatic test_collision;
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_bits(16'h1234, 0, 16);
    din_pin  = 1'b1;
    sclk_pin = 1'b1;
    cyc(8);
    // 17th falling edge lands on the same clk as the SYNC rise.
    sclk_pin = 1'b0;
    sync_pin = 1'b1;
    cyc(12);
    n_vec++; if (valid_cnt - v0 !== 1) begin n_err++; $display("FAIL coll_valid: got %0d pulses want 1", valid_cnt - v0); end
    n_vec++; if (err_cnt - e0 !== 0) begin n_err++; $display("FAIL coll_err: got %0d pulses want 0", err_cnt - e0); end
    n_vec++; if (data0 !== 16'h1234) begin n_err++; $display("FAIL coll_data: got %h want 1234", data0); end
    n_vec++; if (dut0.cnt_q !== 5'd16) begin n_err++; $display("FAIL coll_cnt: got %0d want 16", dut0.cnt_q); end
    din_pin = 1'b0;
  endtask

  task automatic test_reset_mid_frame;
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_bits(16'hBEEF, 0, 8);
    n_vec++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %b want 1", busy0); end
    rst_n = 1'b0;
    cyc(3);
    n_vec++; if (data0 !== 16'h0000) begin n_err++; $display("FAIL mid_rst_data: got %h want 0000", data0); end
    n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", busy0); end
    rst_n = 1'b1;
    send_bits(16'hBEEF, 8, 8);
    sync_pin = 1'b1;
    din_pin  = 1'b0;
    cyc(12);
    n_vec++; if (valid_cnt - v0 !== 0) begin n_err++; $display("FAIL mid_valid: got %0d pulses want 0", valid_cnt - v0); end
    n_vec++; if (err_cnt - e0 !== 0) begin n_err++; $display("FAIL mid_err: got %0d pulses want 0", err_cnt - e0); end
    v0 = valid_cnt;
    frame(16'h5555, 16);
    n_vec++; if (valid_cnt - v0 !== 1) begin n_err++; $display("FAIL mid_next_valid: got %0d pulses want 1", valid_cnt - v0); end
    n_vec++; if (data0 !== 16'h5555) begin n_err++; $display("FAIL mid_next_data: got %h want 5555", data0); end
  endtask

  // Edge 0 is the first posedge that samples SYNC high; strobe expected
  // SYNC_STAGES+2 edges later: 4 for dut0, 5 for dut1.
  task automatic test_latency;
    int lat0, lat1;
    lat0 = -1; lat1 = -1;
    send_bits(16'h00FF, 0, 16);
    sync_pin = 1'b1;
    din_pin  = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (valid0 && lat0 < 0) lat0 = k;
      if (valid1 && lat1 < 0) lat1 = k;
    end
    n_vec++; if (lat1 !== 5) begin n_err++; $display("FAIL lat_dut1: got %0d cycles want 5", lat1); end
    n_vec++; if (data1 !== 16'h00FF) begin n_err++; $display("FAIL lat_data1: got %h want 00ff", data1); end
    n_vec++; if (lat0 !== 4) begin n_err++; $display("FAIL lat_dut0: got %0d cycles want 4", lat0); end
    n_vec++; if (data0 !== 16'h00FF) begin n_err++; $display("FAIL lat_data0: got %h want 00ff", data0); end
    cyc(4);
  endtask

  initial begin
    test_reset();
    test_empty_frame();
    test_loopback();
    test_short_frame();
    test_overrun();
    test_collision();
    test_reset_mid_frame();
    test_latency();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
